// File: rtl/binary_to_bcd_display.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with registered BCD digits and leading-zero blank flags for the display stage.
module binary_to_bcd_display #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    input  logic                  lz_blank_en,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic [1:0]            dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam longint unsigned MAX_BIN  = (64'd1 << WIDTH) - 64'd1;
    localparam longint unsigned DEC_SPAN = 64'd10 ** DIGITS;

    if (DEC_SPAN <= MAX_BIN) begin : g_digits_too_few
        $error("binary_to_bcd_display: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [4*DIGITS-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  lz_q, lz_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]     blank_q, blank_d;

    logic [4*DIGITS-1:0]   adjusted;
    logic [DIGITS-1:0]     zero_mask;
    logic                  upper_zero;

    // Add-3 correction applied before each shift so no digit leaves 0..9.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        zero_mask  = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero   = upper_zero & (scratch_q[4*i +: 4] == 4'd0);
            zero_mask[i] = upper_zero;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        lz_d      = lz_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = value;
                    scratch_d = '0;
                    cnt_d     = '0;
                    lz_d      = lz_blank_en;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {adjusted, shift_q} << 1;
                cnt_d                = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                bcd_d   = scratch_q;
                blank_d = lz_q ? zero_mask : '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            lz_q      <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= '1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            lz_q      <= lz_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign bcd_out   = bcd_q;
    assign blank_out = blank_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_binary_to_bcd_display.sv
// Bench for binary_to_bcd_display: vector table plus hand-built sequences for
// back-to-back starts and mid-conversion reset; results checked via expected queue.
module tb_binary_to_bcd_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] value = '0;
    logic        lz = 1'b0;
    logic        busy, done;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    logic [24:0] exp_q[$];

    typedef struct {
        logic [15:0] v;
        logic        lz;
        logic [19:0] bcd;
        logic [4:0]  blank;
    } vec_t;
    vec_t tbl[10];

    binary_to_bcd_display #(.WIDTH(16), .DIGITS(5)) dut (
        .clock(clk), .reset(rst), .start(start), .value(value),
        .lz_blank_en(lz), .busy(busy), .done(done), .bcd_out(bcd),
        .blank_out(blank), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference built by repeated division.
    function automatic logic [24:0] model(input logic [15:0] v, input logic lzb);
        logic [19:0] b;
        logic [4:0]  bl;
        int          r;
        bit          z;
        r = int'(v);
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        bl = '0;
        if (lzb) begin
            z = 1'b1;
            for (int i = 4; i >= 1; i--) begin
                z = z && (b[4*i +: 4] == 4'd0);
                bl[i] = z;
            end
        end
        return {b, bl};
    endfunction

    // Scoreboard: every done must match the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            logic [24:0] e;
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("bcd_out", 32'(bcd), 32'(e[24:5]));
                check("blank_out", 32'(blank), 32'(e[4:0]));
            end
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input logic [15:0] v, input logic lzb, input logic [24:0] e);
        int lat;
        @(negedge clk);
        start = 1'b1;
        value = v;
        lz    = lzb;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        value = 16'($urandom);
        lz    = 1'($urandom_range(0, 1));
        wait_done(lat);
        check("latency", 32'(lat), 32'd17);
        check("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int d0;
        logic [15:0] rv;
        logic        rl;

        tbl[0] = '{16'd1234,  1'b1, 20'h01234, 5'b10000};
        tbl[1] = '{16'd65535, 1'b1, 20'h65535, 5'b00000};
        tbl[2] = '{16'd0,     1'b1, 20'h00000, 5'b11110};
        tbl[3] = '{16'd7,     1'b0, 20'h00007, 5'b00000};
        tbl[4] = '{16'd9,     1'b1, 20'h00009, 5'b11110};
        tbl[5] = '{16'd10,    1'b1, 20'h00010, 5'b11100};
        tbl[6] = '{16'd10000, 1'b1, 20'h10000, 5'b00000};
        tbl[7] = '{16'd100,   1'b0, 20'h00100, 5'b00000};
        tbl[8] = '{16'd500,   1'b1, 20'h00500, 5'b11000};
        tbl[9] = '{16'd0,     1'b0, 20'h00000, 5'b00000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_blank", 32'(blank), 32'h1f);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_blank", 32'(blank), 32'h1f);
        check("idle_state", 32'(dbg_state), 32'd0);

        foreach (tbl[i]) run_one(tbl[i].v, tbl[i].lz, {tbl[i].bcd, tbl[i].blank});

        for (int i = 0; i < 12; i++) begin
            rv = 16'($urandom_range(0, 65535));
            rl = 1'($urandom_range(0, 1));
            run_one(rv, rl, model(rv, rl));
        end

        // Start held with a new value during busy: ignored; next start lands in the done cycle.
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; value = 16'd1234; lz = 1'b1;
        exp_q.push_back({20'h01234, 5'b10000});
        @(negedge clk);
        value = 16'd9999; lz = 1'b0;
        wait_done(lat);
        check("held_latency", 32'(lat), 32'd17);
        value = 16'd42; lz = 1'b1;
        exp_q.push_back({20'h00042, 5'b11100});
        @(negedge clk);
        start = 1'b0;
        check("done_cycle_accept", 32'(busy), 32'd1);
        wait_done(lat);
        check("second_latency", 32'(lat), 32'd17);
        @(negedge clk);
        check("held_done_count", 32'(n_done - d0), 32'd2);

        // Reset after eight shifts of 65535: immediate reset values, no done.
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; value = 16'd65535; lz = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_bcd", 32'(bcd), 32'h0);
        check("mid_rst_blank", 32'(blank), 32'h1f);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("no_done_after_rst", 32'(n_done - d0), 32'd0);
        check("blank_held_dark", 32'(blank), 32'h1f);
        run_one(16'd100, 1'b1, {20'h00100, 5'b11000});

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
